// File: rtl/mrv32_pkg.sv
// ============================================================================
//  Module      : mrv32_pkg
//  Description : Shared core constants and the memory-port requester ID type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mrv32_pkg;

    localparam int ADDR_WIDTH = 16;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ_LSU = 1'b0;
    localparam req_id_t REQ_DBG = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_id_fifo.sv
// ============================================================================
//  Module      : arb_id_fifo
//  Description : Small FIFO of requester IDs for in-flight reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_id_fifo
    import mrv32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_push,
    input  req_id_t i_push_id,
    input  logic    i_pop,
    output req_id_t o_head_id,
    output logic    o_full,
    output logic    o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

    req_id_t          r_slots [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == C_LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full    = (r_count == C_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_head_id = r_slots[r_rd_ptr];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_slots[r_wr_ptr] <= i_push_id;
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin share of one memory port between LSU and debug
//                DMA, routing in-order read responses back by recorded ID.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mrv32_pkg::*;
#(
    parameter int ADDR_WIDTH      = mrv32_pkg::ADDR_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wstrb,
    output logic [31:0]           m0_rdata,
    output logic                  m0_rvalid,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wstrb,
    output logic [31:0]           m1_rdata,
    output logic                  m1_rvalid,

    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rvalid,

    output logic                  err_orphan
);

    req_id_t r_last_grant;
    logic    r_err_orphan;

    req_id_t w_head_id;
    logic    w_full;
    logic    w_empty;
    logic    w_pop;
    logic    w_push;
    logic    w_req0;
    logic    w_req1;
    logic    w_grant0;
    logic    w_grant1;
    req_id_t w_push_id;

    // A pop this cycle frees a slot, so a read may still be taken when full.
    assign w_pop  = mem_rvalid && !w_empty;
    assign w_req0 = m0_valid && ((m0_wstrb != 4'b0000) || !w_full || w_pop);
    assign w_req1 = m1_valid && ((m1_wstrb != 4'b0000) || !w_full || w_pop);

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_req0 && w_req1) begin
            w_grant0 = (r_last_grant == REQ_DBG);
            w_grant1 = (r_last_grant == REQ_LSU);
        end else begin
            w_grant0 = w_req0;
            w_grant1 = w_req1;
        end
    end

    assign m0_ready = w_grant0;
    assign m1_ready = w_grant1;

    always_comb begin
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        w_push    = 1'b0;
        w_push_id = REQ_LSU;
        if (w_grant0) begin
            mem_valid = 1'b1;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_wstrb = m0_wstrb;
            w_push    = (m0_wstrb == 4'b0000);
            w_push_id = REQ_LSU;
        end else if (w_grant1) begin
            mem_valid = 1'b1;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wstrb = m1_wstrb;
            w_push    = (m1_wstrb == 4'b0000);
            w_push_id = REQ_DBG;
        end
    end

    assign m0_rdata   = mem_rdata;
    assign m1_rdata   = mem_rdata;
    assign m0_rvalid  = w_pop && (w_head_id == REQ_LSU);
    assign m1_rvalid  = w_pop && (w_head_id == REQ_DBG);
    assign err_orphan = r_err_orphan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= REQ_DBG;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_grant0)      r_last_grant <= REQ_LSU;
            else if (w_grant1) r_last_grant <= REQ_DBG;
            if (mem_rvalid && w_empty) r_err_orphan <= 1'b1;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_push_id (w_push_id),
        .i_pop     (w_pop),
        .o_head_id (w_head_id),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed bench; two arbiters (depth 4 and depth 1), each with
//                its own two-cycle-latency word memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    import mrv32_pkg::*;

    localparam int AW = mrv32_pkg::ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;

    logic          m0_valid, m1_valid;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic [3:0]    m0_wstrb, m1_wstrb;

    logic          m0_ready   [2];
    logic          m1_ready   [2];
    logic [31:0]   m0_rdata   [2];
    logic [31:0]   m1_rdata   [2];
    logic          m0_rvalid  [2];
    logic          m1_rvalid  [2];
    logic          mem_valid  [2];
    logic [AW-1:0] mem_addr   [2];
    logic [31:0]   mem_wdata  [2];
    logic [3:0]    mem_wstrb  [2];
    logic [31:0]   mem_rdata  [2];
    logic          mem_rvalid [2];
    logic          err_orphan [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k);
        if (k == 2) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + 32'(k) * 32'h0000_0101;
    endfunction

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            logic [31:0] mem [64];
            logic        p1_v, p2_v;
            logic [31:0] p1_d, p2_d;

            always @(posedge clk) begin
                if (load) begin
                    for (int k = 0; k < 64; k++) mem[k] <= init_word(k);
                end else if (mem_valid[gi] && mem_wstrb[gi] != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[gi][b])
                            mem[mem_addr[gi][7:2]][8*b +: 8] <= mem_wdata[gi][8*b +: 8];
                end
                p1_v <= mem_valid[gi] && (mem_wstrb[gi] == 4'b0000);
                p1_d <= mem[mem_addr[gi][7:2]];
                p2_v <= p1_v;
                p2_d <= p1_d;
            end

            assign mem_rvalid[gi] = p2_v;
            assign mem_rdata[gi]  = p2_d;

            mem_port_arbiter #(
                .ADDR_WIDTH      (AW),
                .MAX_OUTSTANDING ((gi == 0) ? 4 : 1)
            ) dut (
                .clk        (clk),
                .rst_n      (rst_n),
                .m0_valid   (m0_valid),
                .m0_ready   (m0_ready[gi]),
                .m0_addr    (m0_addr),
                .m0_wdata   (m0_wdata),
                .m0_wstrb   (m0_wstrb),
                .m0_rdata   (m0_rdata[gi]),
                .m0_rvalid  (m0_rvalid[gi]),
                .m1_valid   (m1_valid),
                .m1_ready   (m1_ready[gi]),
                .m1_addr    (m1_addr),
                .m1_wdata   (m1_wdata),
                .m1_wstrb   (m1_wstrb),
                .m1_rdata   (m1_rdata[gi]),
                .m1_rvalid  (m1_rvalid[gi]),
                .mem_valid  (mem_valid[gi]),
                .mem_addr   (mem_addr[gi]),
                .mem_wdata  (mem_wdata[gi]),
                .mem_wstrb  (mem_wstrb[gi]),
                .mem_rdata  (mem_rdata[gi]),
                .mem_rvalid (mem_rvalid[gi]),
                .err_orphan (err_orphan[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [31:0] d0,
                         input logic [3:0] s0, input logic v1, input logic [AW-1:0] a1,
                         input logic [31:0] d1, input logic [3:0] s1);
        m0_valid = v0; m0_addr = a0; m0_wdata = d0; m0_wstrb = s0;
        m1_valid = v1; m1_addr = a1; m1_wdata = d1; m1_wstrb = s1;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 4'h0, 1'b0, '0, '0, 4'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_all();
        idle();
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b1;
        idle();
        @(negedge clk);
        @(negedge clk);
        load  = 1'b0;
        rst_n = 1'b1;

        // Reset state
        idle();
        check("rst_mem_valid", 32'(mem_valid[0]), 32'd0);
        check("rst_m0_ready", 32'(m0_ready[0]), 32'd0);
        check("rst_mem_addr", 32'(mem_addr[0]), 32'd0);
        check("rst_rvalid", 32'({m0_rvalid[0], m1_rvalid[0]}), 32'd0);
        check("rst_err", 32'(err_orphan[0]), 32'd0);

        // Single read
        drive(1'b1, 16'h0008, '0, 4'h0, 1'b0, '0, '0, 4'h0);
        check("sr_m0_ready", 32'(m0_ready[0]), 32'd1);
        check("sr_m1_ready", 32'(m1_ready[0]), 32'd0);
        check("sr_mem_addr", 32'(mem_addr[0]), 32'h8);
        tick(); idle();
        check("sr_rvalid_early", 32'(m0_rvalid[0]), 32'd0);
        tick(); idle();
        check("sr_m0_rvalid", 32'(m0_rvalid[0]), 32'd1);
        check("sr_rdata", m0_rdata[0], 32'hDEAD_BEEF);
        check("sr_m1_rvalid", 32'(m1_rvalid[0]), 32'd0);
        tick(); idle();
        check("sr_rvalid_after", 32'(m0_rvalid[0]), 32'd0);

        // Tie round-robin
        reset_all();
        drive(1'b1, 16'h0000, '0, 4'h0, 1'b1, 16'h0040, '0, 4'h0);
        check("rr0_m0_ready", 32'(m0_ready[0]), 32'd1);
        check("rr0_m1_ready", 32'(m1_ready[0]), 32'd0);
        check("rr0_addr", 32'(mem_addr[0]), 32'h00);
        tick();
        drive(1'b1, 16'h0004, '0, 4'h0, 1'b1, 16'h0040, '0, 4'h0);
        check("rr1_m1_ready", 32'(m1_ready[0]), 32'd1);
        check("rr1_m0_ready", 32'(m0_ready[0]), 32'd0);
        check("rr1_addr", 32'(mem_addr[0]), 32'h40);
        tick();
        drive(1'b1, 16'h0004, '0, 4'h0, 1'b1, 16'h0044, '0, 4'h0);
        check("rr2_m0_ready", 32'(m0_ready[0]), 32'd1);
        check("rr2_m0_rvalid", 32'(m0_rvalid[0]), 32'd1);
        check("rr2_m1_rvalid", 32'(m1_rvalid[0]), 32'd0);
        check("rr2_rdata", m0_rdata[0], init_word(0));
        tick();
        drive(1'b1, 16'h0008, '0, 4'h0, 1'b1, 16'h0044, '0, 4'h0);
        check("rr3_m1_ready", 32'(m1_ready[0]), 32'd1);
        check("rr3_m1_rvalid", 32'(m1_rvalid[0]), 32'd1);
        check("rr3_m0_rvalid", 32'(m0_rvalid[0]), 32'd0);
        check("rr3_rdata", m1_rdata[0], init_word(16));
        tick(); idle();
        check("rr4_m0_rvalid", 32'(m0_rvalid[0]), 32'd1);
        check("rr4_rdata", m0_rdata[0], init_word(1));
        tick(); idle();
        check("rr5_m1_rvalid", 32'(m1_rvalid[0]), 32'd1);
        check("rr5_rdata", m1_rdata[0], init_word(17));

        // Full-throughput stream from m1
        reset_all();
        for (int c = 0; c < 9; c++) begin
            if (c < 7) drive(1'b0, '0, '0, 4'h0, 1'b1, AW'(8 + 4 * c), '0, 4'h0);
            else       idle();
            if (c < 7) check($sformatf("st%0d_ready", c), 32'(m1_ready[0]), 32'd1);
            if (c >= 2) begin
                check($sformatf("st%0d_rvalid", c), 32'(m1_rvalid[0]), 32'd1);
                check($sformatf("st%0d_rdata", c), m1_rdata[0], init_word(c));
            end
            tick();
        end
        idle();
        check("st_done_rvalid", 32'(m1_rvalid[0]), 32'd0);

        // FIFO-full stall on the depth-1 instance
        reset_all();
        drive(1'b1, 16'h0000, '0, 4'h0, 1'b0, '0, '0, 4'h0);
        check("fs0_m0_ready", 32'(m0_ready[1]), 32'd1);
        tick();
        drive(1'b1, 16'h0004, '0, 4'h0, 1'b1, 16'h0030, 32'h1234_5678, 4'hF);
        check("fs1_m0_stall", 32'(m0_ready[1]), 32'd0);
        check("fs1_m1_write", 32'(m1_ready[1]), 32'd1);
        check("fs1_wstrb", 32'(mem_wstrb[1]), 32'hF);
        tick();
        drive(1'b1, 16'h0004, '0, 4'h0, 1'b0, '0, '0, 4'h0);
        check("fs2_m0_ready", 32'(m0_ready[1]), 32'd1);
        check("fs2_m0_rvalid", 32'(m0_rvalid[1]), 32'd1);
        check("fs2_rdata", m0_rdata[1], init_word(0));
        tick(); idle();
        check("fs3_rvalid", 32'(m0_rvalid[1]), 32'd0);
        tick(); idle();
        check("fs4_m0_rvalid", 32'(m0_rvalid[1]), 32'd1);
        check("fs4_rdata", m0_rdata[1], init_word(1));

        // Write then read
        reset_all();
        drive(1'b1, 16'h0010, 32'hCAFE_F00D, 4'hF, 1'b0, '0, '0, 4'h0);
        check("wr_m0_ready", 32'(m0_ready[0]), 32'd1);
        check("wr_wdata", mem_wdata[0], 32'hCAFE_F00D);
        tick();
        drive(1'b0, '0, '0, 4'h0, 1'b1, 16'h0010, '0, 4'h0);
        check("wr_m1_ready", 32'(m1_ready[0]), 32'd1);
        tick(); idle();
        check("wr_no_rvalid", 32'({m0_rvalid[0], m1_rvalid[0]}), 32'd0);
        tick(); idle();
        check("wr_m1_rvalid", 32'(m1_rvalid[0]), 32'd1);
        check("wr_rdata", m1_rdata[0], 32'hCAFE_F00D);

        // Reset mid-flight
        reset_all();
        drive(1'b1, 16'h0000, '0, 4'h0, 1'b0, '0, '0, 4'h0);
        check("rm_m0_ready", 32'(m0_ready[0]), 32'd1);
        tick(); idle();
        rst_n = 1'b0;
        #1;
        check("rm_in_reset_ready", 32'(m0_ready[0]), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rm_mem_rvalid", 32'(mem_rvalid[0]), 32'd1);
        check("rm_rvalids", 32'({m0_rvalid[0], m1_rvalid[0]}), 32'd0);
        tick();
        check("rm_err_set", 32'(err_orphan[0]), 32'd1);
        repeat (3) tick();
        drive(1'b1, 16'h0004, '0, 4'h0, 1'b0, '0, '0, 4'h0);
        check("rm_err_sticky", 32'(err_orphan[0]), 32'd1);
        reset_all();
        check("rm_err_clear", 32'(err_orphan[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
